f_stage: RTL and testbench

Fetch stage of the five-stage MIPS pipeline. Holds the architectural fetch PC and drives the instruction-memory address. Produces `F_pc` for the next-PC logic, consumes the `npc` that logic returns, and owns the F/D pipeline register. Also detects fetch address errors (AdEL), tags branch-delay-slot instructions, and squashes or holds fetched instructions under exception, `eret` and stall control.

---
 rtl/f_stage_pkg.sv | 16 +
 rtl/fd_reg.sv | 37 +++
 rtl/f_stage.sv | 56 +++++
 tb/tb_f_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/f_stage_pkg.sv
// f_stage_pkg: shared fetch-stage constants, exception codes and F/D record type
package f_stage_pkg;
  localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_NONE       = 5'd0;
  localparam logic [4:0]  EXC_ADEL       = 5'd4;
  localparam logic [31:0] NOP            = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
    logic        bd;
  } fd_t;
endpackage

// File: rtl/fd_reg.sv
// fd_reg: F/D pipeline register with flush > hold > squash > load priority
module fd_reg
  import f_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic        eret,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic [4:0]  f_exccode,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd
);
  fd_t d_q, d_d;
  always_comb begin
    d_d = req   ? fd_t'{HANDLER_PC, NOP, EXC_NONE, 1'b0} :
          stall ? d_q :
          eret  ? fd_t'{f_pc, NOP, EXC_NONE, 1'b0} :
                  fd_t'{f_pc, f_instr, f_exccode, f_bd};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= fd_t'{PC_RESET, NOP, EXC_NONE, 1'b0};
    else d_q <= d_d;
  end
  assign d_pc      = d_q.pc;
  assign d_instr   = d_q.instr;
  assign d_exccode = d_q.exccode;
  assign d_bd      = d_q.bd;
endmodule

// File: rtl/f_stage.sv
// f_stage: MIPS fetch stage - PC register, AdEL detection, delay-slot tagging, F/D register
module f_stage
  import f_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IM_LO      = IM_LO_DEF,
  parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        D_eret,
  input  logic        D_is_bj,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] i_inst_addr,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd
);
  logic [31:0] pc_q, pc_d, f_instr;
  logic [4:0]  f_exccode;
  logic        f_exc;
  always_comb begin
    pc_d      = req ? HANDLER_PC : stall ? pc_q : npc;
    f_exc     = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    f_instr   = f_exc ? NOP : i_inst_rdata;
    f_exccode = f_exc ? EXC_ADEL : EXC_NONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= PC_RESET;
    else pc_q <= pc_d;
  end
  assign F_pc        = pc_q;
  assign i_inst_addr = pc_q;
  // the instruction fetched while a branch sits in D is its delay slot
  fd_reg #(.PC_RESET(PC_RESET), .HANDLER_PC(HANDLER_PC)) u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .stall     (stall),
    .eret      (D_eret),
    .f_pc      (pc_q),
    .f_instr   (f_instr),
    .f_exccode (f_exccode),
    .f_bd      (D_is_bj),
    .d_pc      (D_pc),
    .d_instr   (D_instr),
    .d_exccode (D_exccode),
    .d_bd      (D_bd)
  );
endmodule

// File: tb/tb_f_stage.sv
// tb_f_stage: directed self-checking bench for the fetch stage
module tb_f_stage;
  logic        clk = 0, reset = 0, stall = 0, req = 0, D_eret = 0, D_is_bj = 0;
  logic        use_ovr = 0;
  logic [31:0] npc_ovr = 0;
  logic [31:0] npc, i_inst_rdata, F_pc, i_inst_addr, D_pc, D_instr;
  logic [4:0]  D_exccode;
  logic        D_bd;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign npc = use_ovr ? npc_ovr : F_pc + 32'd4;
  assign i_inst_rdata = i_inst_addr ^ 32'hA5A5_0000;

  f_stage dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .req(req),
    .D_eret(D_eret), .D_is_bj(D_is_bj), .i_inst_rdata(i_inst_rdata),
    .F_pc(F_pc), .i_inst_addr(i_inst_addr), .D_pc(D_pc), .D_instr(D_instr),
    .D_exccode(D_exccode), .D_bd(D_bd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input logic bd);
    chk({tag, "_dpc"}, D_pc, pc);
    chk({tag, "_dinstr"}, D_instr, instr);
    chk({tag, "_dexc"}, {27'd0, D_exccode}, {27'd0, exc});
    chk({tag, "_dbd"}, {31'd0, D_bd}, {31'd0, bd});
  endtask

  initial begin
    #12;
    chk("rst_fpc", F_pc, 32'h3000);
    chk("rst_iaddr", i_inst_addr, 32'h3000);
    chk_d("rst", 32'h3000, 32'h0, 5'd0, 1'b0);
    reset = 1;
    tick;
    chk("seq1_fpc", F_pc, 32'h3004);
    chk_d("seq1", 32'h3000, 32'hA5A5_3000, 5'd0, 1'b0);
    tick;
    chk("seq2_fpc", F_pc, 32'h3008);
    chk("seq2_dpc", D_pc, 32'h3004);
    tick;
    tick;
    chk("pre_stall_fpc", F_pc, 32'h3010);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_fpc", F_pc, 32'h3010);
      chk_d("stall", 32'h300C, 32'hA5A5_300C, 5'd0, 1'b0);
    end
    stall = 0;
    tick;
    chk("unstall_fpc", F_pc, 32'h3014);
    chk("unstall_dpc", D_pc, 32'h3010);
    tick;
    tick;
    tick;
    chk("bd_pre_fpc", F_pc, 32'h3020);
    D_is_bj = 1;
    tick;
    chk_d("bd", 32'h3020, 32'hA5A5_3020, 5'd0, 1'b1);
    D_is_bj = 0;
    tick;
    chk("bd_clear", {31'd0, D_bd}, 32'd0);
    use_ovr = 1;
    npc_ovr = 32'h3002;
    tick;
    chk("adel_mis_fpc", F_pc, 32'h3002);
    npc_ovr = 32'h7000;
    tick;
    chk_d("adel_mis", 32'h3002, 32'h0, 5'd4, 1'b0);
    npc_ovr = 32'h3040;
    tick;
    chk_d("adel_hi", 32'h7000, 32'h0, 5'd4, 1'b0);
    chk("eret_pre_fpc", F_pc, 32'h3040);
    D_eret = 1;
    npc_ovr = 32'h3104;
    tick;
    chk("eret_fpc", F_pc, 32'h3104);
    chk_d("eret", 32'h3040, 32'h0, 5'd0, 1'b0);
    stall = 1;
    npc_ovr = 32'h3200;
    tick;
    chk("eret_stall_fpc", F_pc, 32'h3104);
    chk("eret_stall_dpc", D_pc, 32'h3040);
    stall = 0;
    tick;
    chk("eret_rel_fpc", F_pc, 32'h3200);
    chk_d("eret_rel", 32'h3104, 32'h0, 5'd0, 1'b0);
    D_eret = 0;
    npc_ovr = 32'h6FFC;
    tick;
    chk("imhi_fpc", F_pc, 32'h6FFC);
    chk("imhi_prev_dinstr", D_instr, 32'hA5A5_3200);
    npc_ovr = 32'h2FFC;
    tick;
    chk_d("imhi", 32'h6FFC, 32'hA5A5_6FFC, 5'd0, 1'b0);
    npc_ovr = 32'h3000;
    tick;
    chk_d("imlo", 32'h2FFC, 32'h0, 5'd4, 1'b0);
    req = 1;
    stall = 1;
    D_is_bj = 1;
    tick;
    chk("req_fpc", F_pc, 32'h4180);
    chk_d("req", 32'h4180, 32'h0, 5'd0, 1'b0);
    req = 0;
    stall = 0;
    D_is_bj = 0;
    use_ovr = 0;
    tick;
    chk("handler_fpc", F_pc, 32'h4184);
    chk_d("handler", 32'h4180, 32'hA5A5_4180, 5'd0, 1'b0);
    #2 reset = 0;
    #1;
    chk("arst_fpc", F_pc, 32'h3000);
    chk_d("arst", 32'h3000, 32'h0, 5'd0, 1'b0);
    reset = 1;
    tick;
    chk("arst_rel_fpc", F_pc, 32'h3004);
    chk_d("arst_rel", 32'h3000, 32'hA5A5_3000, 5'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
